// File: rtl/cpu_pkg.sv
// Shared core constants: ALU op codes and EX-stage forward-select encodings.
package cpu_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SRA = 4'b0011,
    ALU_SLL = 4'b0100,
    ALU_SRL = 4'b0101,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100,
    ALU_XOR = 4'b1101
  } alu_op_e;

  localparam int unsigned FWD_W = 2;
  localparam logic [FWD_W-1:0] FWD_REG   = 2'b00;
  localparam logic [FWD_W-1:0] FWD_MEMWB = 2'b01;
  localparam logic [FWD_W-1:0] FWD_EXMEM = 2'b10;

endpackage

// File: rtl/forwarding_unit.sv
// Combinational RAW forward-select logic for the two EX-stage source operands.
module forwarding_unit
  import cpu_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  output logic [FWD_W-1:0]  fwd_a,
  output logic [FWD_W-1:0]  fwd_b
);

  logic exmem_live;
  logic memwb_live;

  // Register 0 is hardwired, so a write to it is never a forward source.
  always_comb begin
    exmem_live = exmem_reg_write && (exmem_rd != '0);
    memwb_live = memwb_reg_write && (memwb_rd != '0);
  end

  // The younger EX/MEM result takes precedence over MEM/WB.
  always_comb begin
    fwd_a = FWD_REG;
    fwd_b = FWD_REG;
    if (exmem_live && (exmem_rd == ex_rs))      fwd_a = FWD_EXMEM;
    else if (memwb_live && (memwb_rd == ex_rs)) fwd_a = FWD_MEMWB;
    if (exmem_live && (exmem_rd == ex_rt))      fwd_b = FWD_EXMEM;
    else if (memwb_live && (memwb_rd == ex_rt)) fwd_b = FWD_MEMWB;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding, ALU operand
// selection and load-use hazard detection against the decode slot.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_shamt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [3:0]        id_alu_control,
  input  logic              id_alu_src,
  input  logic              id_shamt_sel,
  input  logic              id_reg_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_data,
  output logic              ex_valid,
  output logic [DATA_W-1:0] alu_data1,
  output logic [DATA_W-1:0] alu_data2,
  output logic [3:0]        alu_control,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_dest,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic [FWD_W-1:0]  fwd_a,
  output logic [FWD_W-1:0]  fwd_b,
  output logic              load_use
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [4:0]        shamt;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] dest;
    logic [3:0]        alu_control;
    logic              alu_src;
    logic              shamt_sel;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
  } id_ex_t;

  id_ex_t id_d;
  id_ex_t ex_q;
  logic [DATA_W-1:0] fwd_a_val;
  logic [DATA_W-1:0] fwd_b_val;

  // Destination is resolved here so EX only carries a single index.
  always_comb begin
    id_d             = '0;
    id_d.valid       = id_valid;
    id_d.rs_data     = id_rs_data;
    id_d.rt_data     = id_rt_data;
    id_d.imm         = id_imm;
    id_d.shamt       = id_shamt;
    id_d.rs          = id_rs;
    id_d.rt          = id_rt;
    id_d.dest        = id_reg_dst ? id_rd : id_rt;
    id_d.alu_control = id_alu_control;
    id_d.alu_src     = id_alu_src;
    id_d.shamt_sel   = id_shamt_sel;
    id_d.reg_write   = id_reg_write;
    id_d.mem_read    = id_mem_read;
    id_d.mem_write   = id_mem_write;
    id_d.mem_to_reg  = id_mem_to_reg;
  end

  // A flush overrides a concurrent stall so the bubble always lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       ex_q <= '0;
    else if (flush)  ex_q <= '0;
    else if (!stall) ex_q <= id_d;
  end

  forwarding_unit #(.REG_AW(REG_AW)) u_fwd (
    .ex_rs           (ex_q.rs),
    .ex_rt           (ex_q.rt),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b)
  );

  always_comb begin
    fwd_a_val = ex_q.rs_data;
    fwd_b_val = ex_q.rt_data;
    case (fwd_a)
      FWD_EXMEM: fwd_a_val = exmem_result;
      FWD_MEMWB: fwd_a_val = memwb_data;
      default:   fwd_a_val = ex_q.rs_data;
    endcase
    case (fwd_b)
      FWD_EXMEM: fwd_b_val = exmem_result;
      FWD_MEMWB: fwd_b_val = memwb_data;
      default:   fwd_b_val = ex_q.rt_data;
    endcase
  end

  always_comb begin
    alu_data1     = ex_q.shamt_sel ? DATA_W'(ex_q.shamt) : fwd_a_val;
    alu_data2     = ex_q.alu_src ? ex_q.imm : fwd_b_val;
    ex_store_data = fwd_b_val;
    alu_control   = ex_q.alu_control;
    ex_valid      = ex_q.valid;
    ex_dest       = ex_q.dest;
    ex_reg_write  = ex_q.reg_write;
    ex_mem_read   = ex_q.mem_read;
    ex_mem_write  = ex_q.mem_write;
    ex_mem_to_reg = ex_q.mem_to_reg;
  end

  // Conservative: rt is compared even for instructions that never read it.
  always_comb begin
    load_use = ex_q.valid && ex_q.mem_read && (ex_q.dest != '0) &&
               ((ex_q.dest == id_rs) || (ex_q.dest == id_rt));
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: per-cycle comparison against a behavioural
// model of the EX slot, plus hand-computed spot checks.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush, id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_shamt, id_rs, id_rt, id_rd;
  logic [3:0]  id_alu_control;
  logic        id_alu_src, id_shamt_sel, id_reg_dst;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_data;
  logic        ex_valid;
  logic [31:0] alu_data1, alu_data2, ex_store_data;
  logic [3:0]  alu_control;
  logic [4:0]  ex_dest;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic [1:0]  fwd_a, fwd_b;
  logic        load_use;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_shamt(id_shamt), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_alu_control(id_alu_control), .id_alu_src(id_alu_src),
    .id_shamt_sel(id_shamt_sel), .id_reg_dst(id_reg_dst),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .ex_valid(ex_valid), .alu_data1(alu_data1), .alu_data2(alu_data2),
    .alu_control(alu_control), .ex_store_data(ex_store_data), .ex_dest(ex_dest),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .load_use(load_use)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of the instruction currently sitting in EX.
  logic        m_valid, m_src, m_ssel, m_rw, m_mr, m_mw, m_m2r;
  logic [31:0] m_rsd, m_rtd, m_imm;
  logic [4:0]  m_shamt, m_rs, m_rt, m_dest;
  logic [3:0]  m_ctl;

  task automatic model_clear();
    {m_valid, m_src, m_ssel, m_rw, m_mr, m_mw, m_m2r} = '0;
    m_rsd = 0; m_rtd = 0; m_imm = 0;
    m_shamt = 0; m_rs = 0; m_rt = 0; m_dest = 0; m_ctl = 0;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset || flush) model_clear();
    else if (!stall) begin
      m_valid = id_valid; m_rsd = id_rs_data; m_rtd = id_rt_data; m_imm = id_imm;
      m_shamt = id_shamt; m_rs = id_rs; m_rt = id_rt;
      m_dest  = id_reg_dst ? id_rd : id_rt;
      m_ctl = id_alu_control; m_src = id_alu_src; m_ssel = id_shamt_sel;
      m_rw = id_reg_write; m_mr = id_mem_read; m_mw = id_mem_write; m_m2r = id_mem_to_reg;
    end
  end

  function automatic logic [1:0] exp_sel(input logic [4:0] r);
    if (r == 0) return 2'b00;
    if (exmem_reg_write && exmem_rd == r) return 2'b10;
    if (memwb_reg_write && memwb_rd == r) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] exp_val(input logic [4:0] r, input logic [31:0] regv);
    if (r == 0) return regv;
    if (exmem_reg_write && exmem_rd == r) return exmem_result;
    if (memwb_reg_write && memwb_rd == r) return memwb_data;
    return regv;
  endfunction

  always @(negedge clk) begin
    chk("ex_valid", 32'(ex_valid), 32'(m_valid));
    chk("alu_data1", alu_data1, m_ssel ? {27'd0, m_shamt} : exp_val(m_rs, m_rsd));
    chk("alu_data2", alu_data2, m_src ? m_imm : exp_val(m_rt, m_rtd));
    chk("store_data", ex_store_data, exp_val(m_rt, m_rtd));
    chk("alu_control", 32'(alu_control), 32'(m_ctl));
    chk("ex_dest", 32'(ex_dest), 32'(m_dest));
    chk("ctrl", 32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}),
        32'({m_rw, m_mr, m_mw, m_m2r}));
    chk("fwd_a", 32'(fwd_a), 32'(exp_sel(m_rs)));
    chk("fwd_b", 32'(fwd_b), 32'(exp_sel(m_rt)));
    chk("load_use", 32'(load_use),
        32'(m_valid && m_mr && m_dest != 0 && (m_dest == id_rs || m_dest == id_rt)));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic id_clear();
    id_valid = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_shamt = 0;
    id_rs = 0; id_rt = 0; id_rd = 0; id_alu_control = 0; id_alu_src = 0;
    id_shamt_sel = 0; id_reg_dst = 0; id_reg_write = 0; id_mem_read = 0;
    id_mem_write = 0; id_mem_to_reg = 0;
  endtask

  task automatic id_rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] rsd, input logic [31:0] rtd, input logic [3:0] op);
    id_clear();
    id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd; id_rs_data = rsd; id_rt_data = rtd;
    id_alu_control = op; id_reg_dst = 1; id_reg_write = 1;
  endtask

  initial begin
    reset = 1; stall = 0; flush = 0;
    id_clear();
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_data = 0;
    repeat (2) step();
    chk("rst_valid", 32'(ex_valid), 32'd0);
    chk("rst_fwd", 32'({fwd_a, fwd_b}), 32'd0);
    reset = 0;

    // Capture of a plain add
    id_rtype(5'd1, 5'd2, 5'd4, 32'd5, 32'd7, 4'b0010);
    step();
    id_clear();
    #1;
    chk("cap_d1", alu_data1, 32'd5);
    chk("cap_d2", alu_data2, 32'd7);
    chk("cap_fwd", 32'({fwd_a, fwd_b}), 32'd0);
    chk("cap_dest", 32'(ex_dest), 32'd4);
    chk("cap_ctl", 32'(alu_control), 32'd2);

    // Stall holds EX while decode changes
    stall = 1;
    id_rtype(5'd9, 5'd10, 5'd11, 32'hDEAD, 32'hBEEF, 4'b0110);
    repeat (3) begin
      step();
      chk("stall_d1", alu_data1, 32'd5);
      chk("stall_d2", alu_data2, 32'd7);
    end
    stall = 0;

    // Double forward: EX/MEM beats MEM/WB
    id_rtype(5'd3, 5'd3, 5'd5, 32'hAA, 32'hBB, 4'b0010);
    step();
    id_clear();
    exmem_reg_write = 1; exmem_rd = 3; exmem_result = 32'h11;
    memwb_reg_write = 1; memwb_rd = 3; memwb_data = 32'h22;
    #1;
    chk("dfw_sel", 32'({fwd_a, fwd_b}), 32'b1010);
    chk("dfw_d1", alu_data1, 32'h11);
    chk("dfw_d2", alu_data2, 32'h11);
    exmem_reg_write = 0;
    #1;
    chk("mwb_sel", 32'({fwd_a, fwd_b}), 32'b0101);
    chk("mwb_d1", alu_data1, 32'h22);
    chk("mwb_st", ex_store_data, 32'h22);
    step();

    // Register 0 never forwarded
    id_rtype(5'd0, 5'd0, 5'd6, 32'd9, 32'd12, 4'b0001);
    exmem_reg_write = 1; exmem_rd = 0; exmem_result = 32'h55;
    memwb_reg_write = 1; memwb_rd = 0; memwb_data = 32'h66;
    step();
    id_clear();
    #1;
    chk("r0_fwd", 32'(fwd_a), 32'd0);
    chk("r0_d1", alu_data1, 32'd9);
    chk("r0_d2", alu_data2, 32'd12);
    exmem_reg_write = 0; memwb_reg_write = 0;

    // Shift by 31 with immediate on the B side; store data stays forwarded rt
    id_rtype(5'd7, 5'd8, 5'd9, 32'h100, 32'h3C, 4'b0100);
    id_shamt_sel = 1; id_shamt = 5'd31; id_alu_src = 1; id_imm = 32'hFFFF_FFF0;
    step();
    id_clear();
    #1;
    chk("shf_d1", alu_data1, 32'd31);
    chk("shf_d2", alu_data2, 32'hFFFF_FFF0);
    chk("shf_st", ex_store_data, 32'h3C);

    // Stall and flush together: bubble
    id_rtype(5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 4'b0010);
    stall = 1; flush = 1;
    step();
    stall = 0; flush = 0;
    #1;
    chk("bub_valid", 32'(ex_valid), 32'd0);
    chk("bub_rw", 32'(ex_reg_write), 32'd0);
    chk("bub_d1", alu_data1, 32'd0);

    // Load-use against decode rs/rt
    id_clear();
    id_valid = 1; id_rs = 5'd2; id_rt = 5'd8; id_alu_src = 1; id_imm = 32'd4;
    id_mem_read = 1; id_reg_write = 1; id_mem_to_reg = 1; id_alu_control = 4'b0010;
    step();
    id_clear();
    id_rt = 5'd8;
    #1;
    chk("lu_rt", 32'(load_use), 32'd1);
    id_rt = 5'd9; id_rs = 5'd8;
    #1;
    chk("lu_rs", 32'(load_use), 32'd1);
    id_rs = 5'd2;
    #1;
    chk("lu_none", 32'(load_use), 32'd0);
    id_valid = 1; id_rs = 5'd2; id_rt = 5'd0; id_mem_read = 1; id_reg_write = 1;
    step();
    id_clear();
    #1;
    chk("lu_r0", 32'(load_use), 32'd0);

    // Mid-run asynchronous reset, capture only after release
    id_rtype(5'd4, 5'd5, 5'd6, 32'h77, 32'h88, 4'b0111);
    step();
    reset = 1;
    #1;
    chk("amr_valid", 32'(ex_valid), 32'd0);
    chk("amr_d1", alu_data1, 32'd0);
    chk("amr_d2", alu_data2, 32'd0);
    chk("amr_dest", 32'(ex_dest), 32'd0);
    step();
    reset = 0;
    #1;
    chk("post_rst", 32'(ex_valid), 32'd0);
    step();
    chk("first_cap", 32'(ex_valid), 32'd1);
    chk("first_d1", alu_data1, 32'h77);
    id_clear();
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
